switches_axis: RTL
==================

// Module: switches_axis
// PURPOSE
// AXI-stream master source fed by board switches; the transmit-side counterpart of the LED stream sink.
// Synchronises and debounces the switch vector, then sends each new stable value as one transfer.
// Queues at most one value behind an unaccepted transfer and flags anything it has to drop.
// Connects directly to a DATA_WIDTH stream sink such as the LED block.
// PARAMETERS
// DATA_WIDTH       8   width of sw_i and m_axis_tdata_o
// DEBOUNCE_CYCLES  16  consecutive equal synchronised samples required to accept a value (>=2)
// PORTS
// axis_aclk_i      in   1           single clock; all logic on rising edge
// axis_aresetn_i   in   1           reset, synchronous, active-low
// sw_i             in   DATA_WIDTH  raw asynchronous switch inputs
// m_axis_tready_i  in   1           sink ready
// m_axis_tvalid_o  out  1           transfer valid
// m_axis_tdata_o   out  DATA_WIDTH  transfer data (debounced switch vector)
// drop_o           out  1           one-cycle pulse: a queued value was overwritten before it was sent
// BEHAVIOUR
// Reset (axis_aresetn_i==0 at an edge): sync1, sync2, cand, stable, tdata, pend all 0; cnt=0; pend_v=0;
//   state=ST_IDLE; m_axis_tvalid_o=0, m_axis_tdata_o=0, drop_o=0. Applies mid-transfer: tvalid drops, data is discarded.
// Sync: sync1<=sw_i, sync2<=sync1 (2 flops, whole vector).
// Debounce: if sync2!=cand then cand<=sync2 and cnt<=0.
//   Else if cnt<DEBOUNCE_CYCLES-1 then cnt++.
//   Else (cnt==D-1, saturated): if cand!=stable then stable<=cand and raise a 1-cycle internal event.
//   Counter width is $clog2(DEBOUNCE_CYCLES); the counter saturates and never wraps.
// Latency: sw_i held constant from edge 0 -> stable updates at edge D+3 -> m_axis_tvalid_o=1 after edge D+4 (if idle).
// A glitch shorter than D sync2 cycles never reaches stable. Returning to the old value before acceptance sends nothing.
// Non-zero switches at reset are sent once after debounce, because stable resets to 0.
// FSM ST_IDLE: tvalid=0.
//   On event: tdata<=new stable, tvalid<=1, go to ST_VALID.
// FSM ST_VALID: tvalid=1. tdata is held constant until the handshake (tvalid & tready at an edge).
//   Handshake, no event:
//     pend_v=1 -> tdata<=pend, pend_v<=0, stay.
//     pend_v=0 -> tvalid<=0, go to ST_IDLE.
//   Handshake + event:
//     pend_v=0 -> tdata<=new, stay, no drop.
//     pend_v=1 -> tdata<=pend, pend<=new, pend_v stays 1, no drop.
//   No handshake + event:
//     pend_v=0 -> pend<=new, pend_v<=1.
//     pend_v=1 -> pend<=new, drop_o=1 for exactly that cycle.
// Back-to-back transfers are allowed: tvalid stays high across consecutive handshakes while data remains queued.
// tvalid never depends combinationally on tready; all outputs are registered.
// drop_o is 0 in every cycle other than the overwrite case above.
// TESTING (DATA_WIDTH=8, DEBOUNCE_CYCLES=4, tready=1 unless stated)
// 1 Reset, sw_i=0x00 for 20 cycles -> tvalid stays 0; then sw_i=0xA5 at edge 0 -> tvalid=1, tdata=0xA5 after edge 8, one beat.
// 2 sw_i=0x00 -> 0x3C for 2 cycles -> back to 0x00 -> no transfer, drop_o never 1.
// 3 tready=0; sw_i 0x11, then 0x22 after tvalid -> tdata holds 0x11; on tready=1 beats 0x11 then 0x22 back-to-back; drop_o=0.
// 4 tready=0; stable sequence 0x01,0x02,0x03 -> one drop_o pulse at the 0x03 event; tready=1 sends 0x01 then 0x03.
// 5 Reset asserted for 1 cycle with tvalid=1, pend_v=1 -> next cycle tvalid=0, tdata=0, pend cleared; sw_i=0x0F -> resent after debounce.
// 6 Random sw_i changes spaced >=8 cycles, random tready -> scoreboard: no tdata change while tvalid&!tready; beats match stable sequence minus drops.

Source files
------------

// File: rtl/switches_axis.sv
// AXI-stream master sourced from board switches: two-flop synchroniser, debounce,
// and a one-deep queue behind the current transfer with an overwrite (drop) pulse.
module switches_axis #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  axis_aclk_i,
  input  logic                  axis_aresetn_i,
  input  logic [DATA_WIDTH-1:0] sw_i,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  drop_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] sync1_q, sync2_q;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [DATA_WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  event_q, event_d;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic                  drop_q, drop_d;

  logic                  handshake;

  // Raw switches are asynchronous; only sync2_q may feed any further logic.
  always_ff @(posedge axis_aclk_i) begin
    // NOTE: non-blocking assignments in clocked blocks keep the two flops a real
    // two-stage pipeline instead of collapsing into a single register.
    if (!axis_aresetn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // A value is accepted only after the counter saturates on an unchanged candidate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    event_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      event_d  = 1'b1;
    end
  end

  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      event_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      event_q  <= event_d;
    end
  end

  assign handshake = (state_q == ST_VALID) && m_axis_tready_i;

  // event_q coincides with stable_q already holding the newly accepted value.
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    drop_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (event_q) begin
          tdata_d = stable_q;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (handshake) begin
          if (event_q) begin
            if (pend_v_q) begin
              tdata_d = pend_q;
              pend_d  = stable_q;
            end else begin
              tdata_d = stable_q;
            end
          end else if (pend_v_q) begin
            tdata_d  = pend_q;
            pend_v_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (event_q) begin
          // Only the newest value is kept; an older queued one is lost.
          pend_d   = stable_q;
          pend_v_d = 1'b1;
          drop_d   = pend_v_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      state_q  <= ST_IDLE;
      tdata_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      drop_q   <= drop_d;
    end
  end

  assign m_axis_tvalid_o = (state_q == ST_VALID);
  assign m_axis_tdata_o  = tdata_q;
  assign drop_o          = drop_q;

endmodule
